usb_rx_decoder: RTL and testbench

USB_RX_DECODER -- requirements
Module: usb_rx_decoder

---
 rtl/usb_pkg.sv | 43 ++++
 rtl/usb_nrzi_unstuff.sv | 47 ++++
 rtl/usb_rx_decoder.sv | 187 ++++++++++++++++++
 tb/tb_usb_rx_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB receive definitions: line states, PID codes, FSM states and
// error codes used by the NRZI front end and the packet decoder.
package usb_pkg;

  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2
  } line_state_t;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_PID      = 3'd2,
    ST_DATA     = 3'd3,
    ST_EOP_WAIT = 3'd4,
    ST_ABORT    = 3'd5
  } rx_state_t;

  localparam logic [1:0] ERR_STUFF   = 2'd0;
  localparam logic [1:0] ERR_PID     = 2'd1;
  localparam logic [1:0] ERR_PARTIAL = 2'd2;
  localparam logic [1:0] ERR_OVERLEN = 2'd3;

  // Both lines high is electrically invalid; it is folded into SE0.
  function automatic line_state_t decode_line(input logic dp, input logic dm);
    if (dp && !dm)      return LS_J;
    else if (!dp && dm) return LS_K;
    else                return LS_SE0;
  endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder with bit unstuffing. Outputs are combinational on the current
// line sample; the FSM registers anything it derives from them.
module usb_nrzi_unstuff
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_dp,
  input  logic i_dm,
  input  logic i_active,
  output logic o_bit,
  output logic o_bit_valid,
  output logic o_stuff_err,
  output logic o_se0
);

  line_state_t w_ls;
  logic        w_is_k;
  logic        w_slot;
  logic        r_prev_k;
  logic [2:0]  r_ones;

  assign w_ls        = decode_line(i_dp, i_dm);
  assign w_is_k      = (w_ls == LS_K);
  assign o_se0       = (w_ls == LS_SE0);
  assign o_bit       = (w_is_k == r_prev_k);
  assign w_slot      = (r_ones == 3'd6);
  // The bit after six ones is either a stuffed zero to drop or a violation.
  assign o_bit_valid = !o_se0 && !w_slot;
  assign o_stuff_err = !o_se0 && w_slot && o_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_k <= 1'b0;
      r_ones   <= 3'd0;
    end else begin
      if (!o_se0) r_prev_k <= w_is_k;
      if (!i_active) begin
        r_ones <= 3'd0;
      end else if (!o_se0) begin
        if (w_slot || !o_bit) r_ones <= 3'd0;
        else                  r_ones <= r_ones + 3'd1;
      end
    end
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB low-level packet receiver: sync detection, PID check, byte assembly and
// EOP validation. All pulse outputs are registered and mutually exclusive.
module usb_rx_decoder
  import usb_pkg::*;
#(
  parameter int SYNC_BITS      = 8,
  parameter int MAX_DATA_BYTES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dp_in,
  input  logic       dm_in,
  input  logic       rx_enable,
  output logic [3:0] pid_out,
  output logic       pid_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       eop,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int SW = $clog2(SYNC_BITS) + 1;
  localparam int BW = $clog2(MAX_DATA_BYTES + 1) + 1;

  rx_state_t   r_state;
  logic [SW-1:0] r_sync_cnt;
  logic [BW-1:0] r_byte_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [1:0]  r_se0_cnt;
  logic        r_err_seen;
  logic        w_bit, w_bit_valid, w_stuff_err, w_se0;
  logic        w_line_j, w_line_k, w_sync_last;
  logic [7:0]  w_shift_next;
  line_state_t w_ls;

  usb_nrzi_unstuff u_nrzi (
    .clk         (clk),
    .rst         (rst),
    .i_dp        (dp_in),
    .i_dm        (dm_in),
    .i_active    (busy),
    .o_bit       (w_bit),
    .o_bit_valid (w_bit_valid),
    .o_stuff_err (w_stuff_err),
    .o_se0       (w_se0)
  );

  assign w_ls         = decode_line(dp_in, dm_in);
  assign w_line_j     = (w_ls == LS_J);
  assign w_line_k     = (w_ls == LS_K);
  assign w_shift_next = {w_bit, r_shift[7:1]};
  assign w_sync_last  = (r_sync_cnt == SW'(SYNC_BITS - 1));
  assign busy         = (r_state != ST_IDLE);
  assign dbg_state    = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sync_cnt <= '0;
      r_byte_cnt <= '0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_se0_cnt  <= 2'd0;
      r_err_seen <= 1'b0;
      pid_out    <= 4'd0;
      pid_valid  <= 1'b0;
      byte_out   <= 8'd0;
      byte_valid <= 1'b0;
      eop        <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      pid_valid  <= 1'b0;
      byte_valid <= 1'b0;
      eop        <= 1'b0;
      err        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // The first K is itself the leading zero of the sync field.
          if (rx_enable && w_line_k) begin
            r_state    <= ST_SYNC;
            r_sync_cnt <= SW'(1);
            r_err_seen <= 1'b0;
          end
        end
        ST_SYNC: begin
          if (w_se0 || w_stuff_err) begin
            r_state <= ST_IDLE;
          end else if (w_bit_valid) begin
            if (w_bit != w_sync_last) begin
              r_state <= ST_IDLE;
            end else if (w_sync_last) begin
              r_state   <= ST_PID;
              r_bit_cnt <= 3'd0;
            end else begin
              r_sync_cnt <= r_sync_cnt + SW'(1);
            end
          end
        end
        ST_PID: begin
          if (w_se0) begin
            err        <= 1'b1;
            err_code   <= ERR_PARTIAL;
            r_err_seen <= 1'b1;
            r_se0_cnt  <= 2'd1;
            r_state    <= ST_EOP_WAIT;
          end else if (w_stuff_err) begin
            err       <= 1'b1;
            err_code  <= ERR_STUFF;
            r_se0_cnt <= 2'd0;
            r_state   <= ST_ABORT;
          end else if (w_bit_valid) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (w_shift_next[3:0] == ~w_shift_next[7:4]) begin
                pid_out    <= w_shift_next[3:0];
                pid_valid  <= 1'b1;
                r_byte_cnt <= '0;
                r_state    <= ST_DATA;
              end else begin
                err       <= 1'b1;
                err_code  <= ERR_PID;
                r_se0_cnt <= 2'd0;
                r_state   <= ST_ABORT;
              end
            end
          end
        end
        ST_DATA: begin
          if (w_se0) begin
            if (r_bit_cnt != 3'd0) begin
              err        <= 1'b1;
              err_code   <= ERR_PARTIAL;
              r_err_seen <= 1'b1;
            end
            r_se0_cnt <= 2'd1;
            r_state   <= ST_EOP_WAIT;
          end else if (w_stuff_err) begin
            err       <= 1'b1;
            err_code  <= ERR_STUFF;
            r_se0_cnt <= 2'd0;
            r_state   <= ST_ABORT;
          end else if (w_bit_valid) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (r_byte_cnt == BW'(MAX_DATA_BYTES)) begin
                err       <= 1'b1;
                err_code  <= ERR_OVERLEN;
                r_se0_cnt <= 2'd0;
                r_state   <= ST_ABORT;
              end else begin
                byte_out   <= w_shift_next;
                byte_valid <= 1'b1;
                r_byte_cnt <= r_byte_cnt + BW'(1);
              end
            end
          end
        end
        ST_EOP_WAIT: begin
          if (w_se0) begin
            if (r_se0_cnt != 2'd3) r_se0_cnt <= r_se0_cnt + 2'd1;
          end else begin
            if (w_line_j && r_se0_cnt == 2'd2 && !r_err_seen) eop <= 1'b1;
            r_se0_cnt <= 2'd0;
            r_state   <= w_line_j ? ST_IDLE : ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (w_se0) begin
            r_se0_cnt <= 2'd1;
          end else if (r_se0_cnt != 2'd0) begin
            r_se0_cnt <= 2'd0;
            if (w_line_j) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: packets are built as logical bits, stuffed and
// NRZI-encoded here, and decoder events are checked against a packet model.
module tb_usb_rx_decoder;

  localparam int MAX_BYTES = 10;
  localparam int SYNC_LEN  = 8;
  localparam logic [1:0] EV_PID = 2'd0, EV_BYTE = 2'd1, EV_EOP = 2'd2, EV_ERR = 2'd3;
  localparam logic [7:0] E_STUFF = 8'd0, E_PID = 8'd1, E_PARTIAL = 8'd2, E_OVERLEN = 8'd3;

  logic       clk = 1'b0;
  logic       rst, dp_in, dm_in, rx_enable;
  logic [3:0] pid_out;
  logic       pid_valid, byte_valid, eop, err, busy;
  logic [7:0] byte_out;
  logic [1:0] err_code;
  logic [2:0] dbg_state;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  bit         bits_q[$];
  logic [7:0] data_a[$];
  bit         se0_high = 1'b0;
  bit         busy_seen = 1'b0;
  logic [7:0] valid_pids [8] = '{8'hE1, 8'h69, 8'h2D, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E};

  always #5 clk = ~clk;

  usb_rx_decoder #(.SYNC_BITS(8), .MAX_DATA_BYTES(MAX_BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .dp_in      (dp_in),
    .dm_in      (dm_in),
    .rx_enable  (rx_enable),
    .pid_out    (pid_out),
    .pid_valid  (pid_valid),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .eop        (eop),
    .err        (err),
    .err_code   (err_code),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  function automatic logic [9:0] ev(input logic [1:0] t, input logic [7:0] v);
    return {t, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Monitor: every output pulse is one event, matched in order against exp_q.
  always @(negedge clk) begin
    if (!rst) begin
      int n;
      logic [9:0] act, want;
      if (busy) busy_seen = 1'b1;
      n = int'(pid_valid) + int'(byte_valid) + int'(eop) + int'(err);
      if (n > 1) begin
        check("pulse_exclusive", n, 1);
      end else if (n == 1) begin
        if (pid_valid)       act = ev(EV_PID, {4'h0, pid_out});
        else if (byte_valid) act = ev(EV_BYTE, byte_out);
        else if (eop)        act = ev(EV_EOP, 8'h00);
        else                 act = ev(EV_ERR, {6'h0, err_code});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h expected none", act);
        end else begin
          want = exp_q.pop_front();
          check("event", act, want);
        end
      end
    end
  end

  task automatic drive_line(input int ls);
    case (ls)
      0:       {dp_in, dm_in} = 2'b10;
      1:       {dp_in, dm_in} = 2'b01;
      default: {dp_in, dm_in} = se0_high ? 2'b11 : 2'b00;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bits_q.push_back(b[i]);
  endtask

  task automatic transmit(input bit do_stuff, input int n_se0, input int rst_at, input int drop_at);
    bit enc[$];
    int ones;
    bit lvl_k;
    ones  = 0;
    lvl_k = 1'b0;
    for (int i = 0; i < SYNC_LEN + bits_q.size(); i++) begin
      bit b;
      b = (i < SYNC_LEN) ? (i == SYNC_LEN - 1) : bits_q[i - SYNC_LEN];
      enc.push_back(b);
      ones = b ? ones + 1 : 0;
      if (do_stuff && ones == 6) begin
        enc.push_back(1'b0);
        ones = 0;
      end
    end
    for (int i = 0; i < enc.size(); i++) begin
      if (i == rst_at) begin
        {dp_in, dm_in} = 2'b10;
        rst = 1'b1;
        #1;
        check("rst_outputs", {pid_out, pid_valid, byte_out, byte_valid, eop, err, err_code, busy}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) drive_line(0);
        bits_q.delete();
        return;
      end
      if (i == drop_at) rx_enable = 1'b0;
      if (!enc[i]) lvl_k = !lvl_k;
      drive_line(lvl_k ? 1 : 0);
    end
    repeat (n_se0) drive_line(2);
    repeat (4) drive_line(0);
    rx_enable = 1'b1;
    check("busy_after_packet", busy, 0);
    bits_q.delete();
  endtask

  // Packet-level model: PID check, byte limit, partial byte and EOP shape.
  task automatic send_packet(input logic [7:0] pid_b, input int n_extra, input int n_se0, input int drop_at);
    bit done;
    done = 1'b0;
    if (pid_b[3:0] != ~pid_b[7:4]) begin
      exp_q.push_back(ev(EV_ERR, E_PID));
      done = 1'b1;
    end else begin
      exp_q.push_back(ev(EV_PID, {4'h0, pid_b[3:0]}));
    end
    for (int i = 0; i < data_a.size() && !done; i++) begin
      if (i >= MAX_BYTES) begin
        exp_q.push_back(ev(EV_ERR, E_OVERLEN));
        done = 1'b1;
      end else begin
        exp_q.push_back(ev(EV_BYTE, data_a[i]));
      end
    end
    if (!done) begin
      if (n_extra != 0)    exp_q.push_back(ev(EV_ERR, E_PARTIAL));
      else if (n_se0 == 2) exp_q.push_back(ev(EV_EOP, 8'h00));
    end
    push_byte(pid_b);
    foreach (data_a[i]) push_byte(data_a[i]);
    for (int i = 0; i < n_extra; i++) bits_q.push_back(1'($urandom_range(0, 1)));
    data_a.delete();
    transmit(1'b1, n_se0, -1, drop_at);
  endtask

  initial begin
    rst = 1'b1;
    {dp_in, dm_in} = 2'b10;
    rx_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {pid_out, pid_valid, byte_out, byte_valid, eop, err, err_code, busy, dbg_state}, 0);
    rst = 1'b0;
    repeat (3) drive_line(0);

    // OUT token: addr 5, ep 4 (CRC5 bits arbitrary, not checked by the decoder)
    data_a = '{8'h05, 8'h72};
    send_packet(8'hE1, 0, 2, -1);

    // DATA0 with 0x3F,0xFF forcing stuffed zeros, then two CRC bytes
    data_a = '{8'h3F, 8'hFF, 8'hA5, 8'h5A};
    send_packet(8'hC3, 0, 2, -1);

    // Seven raw ones right after sync: stuffing violation inside the PID
    for (int i = 0; i < 7; i++) bits_q.push_back(1'b1);
    exp_q.push_back(ev(EV_ERR, E_STUFF));
    transmit(1'b0, 2, -1, -1);

    send_packet(8'h11, 0, 2, -1);
    send_packet(8'h4B, 3, 2, -1);

    // SE0 after three PID bits
    bits_q = '{1'b1, 1'b0, 1'b1};
    exp_q.push_back(ev(EV_ERR, E_PARTIAL));
    transmit(1'b1, 2, -1, -1);

    // Reset in the middle of the first data byte, then an ACK
    exp_q.push_back(ev(EV_PID, 8'h0B));
    push_byte(8'h4B);
    push_byte(8'h00);
    push_byte(8'h00);
    transmit(1'b1, 2, 20, -1);
    send_packet(8'hD2, 0, 2, -1);

    // Receiver disabled: the whole packet is ignored
    rx_enable = 1'b0;
    busy_seen = 1'b0;
    push_byte(8'hE1);
    push_byte(8'h05);
    transmit(1'b1, 2, -1, -1);
    check("disabled_never_busy", busy_seen, 0);

    data_a = '{8'h12, 8'h34};
    send_packet(8'h69, 0, 2, 12);

    for (int i = 0; i < MAX_BYTES; i++) data_a.push_back(8'(i * 17));
    send_packet(8'hC3, 0, 2, -1);
    for (int i = 0; i < MAX_BYTES + 1; i++) data_a.push_back(8'hFF);
    send_packet(8'h4B, 0, 2, -1);

    data_a = '{8'h77};
    send_packet(8'h4B, 0, 3, -1);
    data_a = '{8'h88};
    send_packet(8'hC3, 0, 1, -1);

    for (int p = 0; p < 30; p++) begin
      logic [7:0] pid_b;
      int n_data, n_extra, n_se0;
      pid_b    = ($urandom_range(0, 9) < 8) ? valid_pids[$urandom_range(0, 7)] : 8'($urandom);
      n_data   = $urandom_range(0, MAX_BYTES + 2);
      n_extra  = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 7);
      n_se0    = ($urandom_range(0, 9) < 8) ? 2 : $urandom_range(1, 3);
      se0_high = 1'($urandom_range(0, 1));
      for (int i = 0; i < n_data; i++)
        data_a.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      send_packet(pid_b, n_extra, n_se0, -1);
      repeat ($urandom_range(0, 3)) drive_line(0);
    end

    repeat (5) drive_line(0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
